// File: rtl/warpmesh_fetch.sv
// warpmesh_fetch
//   WISHBONE classic-cycle read master. On a start pulse it walks the warp
//   mesh point table row by row, starting at meshaddr. It issues one
//   single-beat read per point and hands each word, tagged with its (x,y)
//   position, to the mesh interpolation stage over a valid/ready handshake.
//   Only one access is in flight at a time: either the bus read or the
//   output word.
//
// Ports
//   wb_clk_i, wb_rst_n_i      clock, async active-low reset
//   start_i                   one-cycle start pulse (ignored while busy)
//   meshaddr_i                word address of the first point
//   meshcountx_i/meshcounty_i points per row / number of rows
//   busy_o, done_o            fetch in progress / completion pulse
//   wbm_*                     WISHBONE master (read-only, 32-bit, all lanes)
//   mesh_valid_o/ready_i      output handshake
//   mesh_data_o, mesh_x_o, mesh_y_o, mesh_last_o  output word and its tags
module warpmesh_fetch (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  input  logic [29:0] meshaddr_i,
  input  logic [6:0]  meshcountx_i,
  input  logic [6:0]  meshcounty_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        mesh_valid_o,
  input  logic        mesh_ready_i,
  output logic [31:0] mesh_data_o,
  output logic [6:0]  mesh_x_o,
  output logic [6:0]  mesh_y_o,
  output logic        mesh_last_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_OUT} state_e;

  state_e      state_q;
  logic [29:0] addr_q;
  logic [6:0]  cntx_q, cnty_q;
  logic [6:0]  x_q, y_q;
  logic [31:0] data_q;
  logic        cyc_q, valid_q, busy_q, done_q, last_q;

  // Position of the following point, and whether the current point is final.
  logic       x_wrap;
  logic       last_d;
  logic [6:0] x_d, y_d;

  always_comb begin
    x_wrap = (x_q == cntx_q - 7'd1);
    last_d = x_wrap && (y_q == cnty_q - 7'd1);
    x_d    = x_wrap ? 7'd0 : x_q + 7'd1;
    y_d    = x_wrap ? y_q + 7'd1 : y_q;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cntx_q  <= '0;
      cnty_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      cyc_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q <= meshaddr_i;
            cntx_q <= meshcountx_i;
            cnty_q <= meshcounty_i;
            x_q    <= '0;
            y_q    <= '0;
            // An empty mesh completes immediately without touching the bus.
            if (meshcountx_i == 7'd0 || meshcounty_i == 7'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_READ;
              cyc_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (wbm_ack_i) begin
            data_q  <= wbm_dat_i;
            cyc_q   <= 1'b0;
            valid_q <= 1'b1;
            last_q  <= last_d;
            state_q <= S_OUT;
          end
        end
        S_OUT: begin
          if (mesh_ready_i) begin
            valid_q <= 1'b0;
            if (last_q) begin
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              addr_q  <= addr_q + 30'd1;  // wraps silently at the top of memory
              x_q     <= x_d;
              y_q     <= y_d;
              cyc_q   <= 1'b1;
              state_q <= S_READ;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          cyc_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign wbm_adr_o    = {addr_q, 2'b00};
  assign wbm_cyc_o    = cyc_q;
  assign wbm_stb_o    = cyc_q;
  assign wbm_we_o     = 1'b0;
  assign wbm_sel_o    = 4'hf;
  assign mesh_valid_o = valid_q;
  assign mesh_data_o  = data_q;
  assign mesh_x_o     = x_q;
  assign mesh_y_o     = y_q;
  assign mesh_last_o  = last_q;

endmodule
